// File: rtl/pcieifc_fifo_pkg.sv
// Shared helpers for the multi-channel FIFO controller: width math and
// the packed per-channel count layout.
package pcieifc_fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pointers carry one extra bit so full and empty stay distinguishable.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int count_lsb(input int ch, input int aw);
    return ch * ptr_w(aw);
  endfunction

endpackage

// File: rtl/pcieifc_fifo_ch_ctrl.sv
// One channel's pointers, fill count, registered flags and sticky errors.
// Acceptance decisions are made by the parent; this block only tracks state.
module pcieifc_fifo_ch_ctrl
  import pcieifc_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int AFULL_TH   = 28,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  err_clr,
  input  logic                  wacc_i,
  input  logic                  racc_i,
  input  logic                  winc_miss,
  input  logic                  rinc_miss,
  output logic [ADDR_WIDTH-1:0] wadr,
  output logic [ADDR_WIDTH-1:0] radr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam int PTR_W = ptr_w(ADDR_WIDTH);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = count;
    if (wacc_i && !racc_i)
      cnt_nxt = count + PTR_W'(1);
    else if (racc_i && !wacc_i)
      cnt_nxt = count - PTR_W'(1);
  end

  // Flags are derived from the next count so they line up with count itself.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      if (wacc_i) wptr <= wptr + PTR_W'(1);
      if (racc_i) rptr <= rptr + PTR_W'(1);
      count  <= cnt_nxt;
      full   <= (cnt_nxt == PTR_W'(1 << ADDR_WIDTH));
      empty  <= (cnt_nxt == '0);
      afull  <= (cnt_nxt >= PTR_W'(AFULL_TH));
      aempty <= (cnt_nxt <= PTR_W'(AEMPTY_TH));
    end
  end

  // A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      ovf_err <= winc_miss | (ovf_err & ~err_clr);
      udf_err <= rinc_miss | (udf_err & ~err_clr);
    end
  end

  assign wadr = wptr[ADDR_WIDTH-1:0];
  assign radr = rptr[ADDR_WIDTH-1:0];

endmodule

// File: rtl/pcieifc_mc_sync_fifo_ctrl.sv
// Multi-channel single-clock FIFO controller over one shared dual-port SRAM.
// Top level decodes channels, muxes SRAM addresses and aligns read data.
module pcieifc_mc_sync_fifo_ctrl
  import pcieifc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = clog2(NUM_CH),
  parameter int AFULL_TH   = 28,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH-1:0]                 clr,
  input  logic                              winc,
  input  logic [CH_W-1:0]                   wch,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic                              rinc,
  input  logic [CH_W-1:0]                   rch,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              rvalid,
  output logic [NUM_CH-1:0]                 full,
  output logic [NUM_CH-1:0]                 empty,
  output logic [NUM_CH-1:0]                 afull,
  output logic [NUM_CH-1:0]                 aempty,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]  count,
  output logic [NUM_CH-1:0]                 ovf_err,
  output logic [NUM_CH-1:0]                 udf_err,
  input  logic                              err_clr,
  output logic [CH_W+ADDR_WIDTH-1:0]        waddr,
  output logic                              wcen,
  output logic [DATA_WIDTH-1:0]             wdin,
  output logic [CH_W+ADDR_WIDTH-1:0]        raddr,
  output logic                              rcen,
  input  logic [DATA_WIDTH-1:0]             rdout
);

  localparam int PTR_W = ptr_w(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wadr_a [NUM_CH];
  logic [ADDR_WIDTH-1:0] radr_a [NUM_CH];
  logic                  wacc;
  logic                  racc;
  logic                  vld_p1;

  // Acceptance uses registered flags only; no same-cycle write-to-read bypass.
  assign wacc = winc & ~rst & ~full[wch]  & ~clr[wch];
  assign racc = rinc & ~rst & ~empty[rch] & ~clr[rch];

  assign wcen  = wacc;
  assign waddr = {wch, wadr_a[wch]};
  assign wdin  = wdata;
  assign rcen  = racc;
  assign raddr = {rch, radr_a[rch]};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wsel;
    logic rsel;
    assign wsel = (wch == CH_W'(i));
    assign rsel = (rch == CH_W'(i));

    pcieifc_fifo_ch_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .AFULL_TH   (AFULL_TH),
      .AEMPTY_TH  (AEMPTY_TH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr[i]),
      .err_clr   (err_clr),
      .wacc_i    (wacc & wsel),
      .racc_i    (racc & rsel),
      .winc_miss (winc & ~rst & wsel & full[i]  & ~clr[i]),
      .rinc_miss (rinc & ~rst & rsel & empty[i] & ~clr[i]),
      .wadr      (wadr_a[i]),
      .radr      (radr_a[i]),
      .count     (count[count_lsb(i, ADDR_WIDTH) +: PTR_W]),
      .full      (full[i]),
      .empty     (empty[i]),
      .afull     (afull[i]),
      .aempty    (aempty[i]),
      .ovf_err   (ovf_err[i]),
      .udf_err   (udf_err[i])
    );
  end

  // Stage p1: SRAM returns data one cycle after rcen.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= racc;
  end

  assign rvalid = vld_p1;
  assign rdata  = vld_p1 ? rdout : '0;

endmodule
